lcd_frame_sequencer: RTL and testbench

Full-frame pixel sequencer that sits between the SoC control logic and the ILI9341 parallel LCD driver. On a start pulse it repositions the driver cursor and streams exactly WIDTH×HEIGHT RGB565 pixels through the driver's pixel handshake, honouring the driver's busy flag. Pixels come from a selectable generator: solid fill, checkerboard, colour bars or gradient. It reports completion with a one-cycle done pulse and can be aborted at any time.

---
 rtl/lcd_frame_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - full-frame RGB565 pixel sequencer for the ILI9341 parallel driver
//
// Purpose: on an accepted start, requests a driver cursor reset and then streams
// WIDTH x HEIGHT generated pixels through the driver's request/busy handshake.
// Each request is held as a level until lcd_busy is seen high.
// Ports:
//   clk_16MHz, reset          clock, synchronous active-high reset
//   start, abort              frame request (IDLE only), frame cancel (level)
//   mode[1:0], color[15:0]    pattern select and base colour, latched on start
//   seq_busy, done            activity flag, one-cycle end-of-frame pulse
//   lcd_busy                  driver busy flag
//   lcd_reset_cursor          cursor-reset request to the driver
//   lcd_pix_clk               pixel-write request to the driver
//   lcd_pix_data[15:0]        pixel value, paired with pix_x/pix_y
//   pix_x[8:0], pix_y[8:0]    coordinates of the value on lcd_pix_data
module lcd_frame_sequencer #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int BAR_W  = 30
) (
    input  logic        clk_16MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [15:0] color,
    output logic        seq_busy,
    output logic        done,
    input  logic        lcd_busy,
    output logic        lcd_reset_cursor,
    output logic        lcd_pix_clk,
    output logic [15:0] lcd_pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y
);

    localparam int             BCW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [8:0]     X_LAST   = 9'(WIDTH - 1);
    localparam logic [8:0]     Y_LAST   = 9'(HEIGHT - 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    typedef enum logic [2:0] {IDLE, CUR_REQ, CUR_WAIT, PIX_REQ, PIX_WAIT} state_t;

    state_t         state_q, state_d;
    logic           seq_busy_q, seq_busy_d;
    logic           done_q, done_d;
    logic           rcur_q, rcur_d;
    logic           pclk_q, pclk_d;
    logic [15:0]    data_q, data_d;
    logic [8:0]     x_q, x_d;
    logic [8:0]     y_q, y_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    color_q, color_d;
    logic [2:0]     bar_q, bar_d;
    logic [BCW-1:0] bar_cnt_q, bar_cnt_d;

    logic [8:0]     x_nx, y_nx;
    logic [2:0]     bar_nx;
    logic [BCW-1:0] bar_cnt_nx;

    function automatic logic [15:0] gen_pixel(input logic [1:0]  m,
                                              input logic [15:0] c,
                                              input logic [8:0]  px,
                                              input logic [8:0]  py,
                                              input logic [2:0]  b);
        logic [15:0] bar_color;
        case (b)
            3'd0: bar_color = 16'hFFFF;
            3'd1: bar_color = 16'hFFE0;
            3'd2: bar_color = 16'h07FF;
            3'd3: bar_color = 16'h07E0;
            3'd4: bar_color = 16'hF81F;
            3'd5: bar_color = 16'hF800;
            3'd6: bar_color = 16'h001F;
            3'd7: bar_color = 16'h0000;
        endcase
        case (m)
            2'd0: return c;
            2'd1: return (px[3] ^ py[3]) ? ~c : c;
            2'd2: return bar_color;
            2'd3: return {px[7:3], py[8:3], ~px[7:3]};
        endcase
    endfunction

    always_comb begin
        // Raster advance; the bar index uses a column counter instead of a divider
        // and saturates at 7 so the tail of a wide row stays black.
        if (x_q == X_LAST) begin
            x_nx       = 9'd0;
            y_nx       = y_q + 9'd1;
            bar_nx     = 3'd0;
            bar_cnt_nx = '0;
        end else begin
            x_nx = x_q + 9'd1;
            y_nx = y_q;
            if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_nx = '0;
                bar_nx     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
            end else begin
                bar_cnt_nx = bar_cnt_q + BCW'(1);
                bar_nx     = bar_q;
            end
        end

        state_d   = state_q;
        done_d    = 1'b0;
        rcur_d    = rcur_q;
        pclk_d    = pclk_q;
        data_d    = data_q;
        x_d       = x_q;
        y_d       = y_q;
        mode_d    = mode_q;
        color_d   = color_q;
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d    = mode;
                    color_d   = color;
                    x_d       = 9'd0;
                    y_d       = 9'd0;
                    bar_d     = 3'd0;
                    bar_cnt_d = '0;
                    // Load pixel (0,0) now so pix_x/pix_y always describe lcd_pix_data.
                    data_d    = gen_pixel(mode, color, 9'd0, 9'd0, 3'd0);
                    rcur_d    = 1'b1;
                    state_d   = CUR_REQ;
                end
            end
            CUR_REQ: begin
                if (lcd_busy) begin
                    rcur_d  = 1'b0;
                    state_d = CUR_WAIT;
                end
            end
            CUR_WAIT: begin
                if (!lcd_busy) begin
                    pclk_d  = 1'b1;
                    state_d = PIX_REQ;
                end
            end
            PIX_REQ: begin
                if (lcd_busy) begin
                    pclk_d  = 1'b0;
                    state_d = PIX_WAIT;
                end
            end
            PIX_WAIT: begin
                if (!lcd_busy) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        x_d       = x_nx;
                        y_d       = y_nx;
                        bar_d     = bar_nx;
                        bar_cnt_d = bar_cnt_nx;
                        data_d    = gen_pixel(mode_q, color_q, x_nx, y_nx, bar_nx);
                        pclk_d    = 1'b1;
                        state_d   = PIX_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything outside IDLE; a byte already in flight in
        // the driver finishes by itself.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            rcur_d  = 1'b0;
            pclk_d  = 1'b0;
            done_d  = 1'b0;
        end

        seq_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_16MHz) begin
        if (reset) begin
            state_q    <= IDLE;
            seq_busy_q <= 1'b0;
            done_q     <= 1'b0;
            rcur_q     <= 1'b0;
            pclk_q     <= 1'b0;
            data_q     <= 16'h0000;
            x_q        <= 9'd0;
            y_q        <= 9'd0;
            mode_q     <= 2'd0;
            color_q    <= 16'h0000;
            bar_q      <= 3'd0;
            bar_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            seq_busy_q <= seq_busy_d;
            done_q     <= done_d;
            rcur_q     <= rcur_d;
            pclk_q     <= pclk_d;
            data_q     <= data_d;
            x_q        <= x_d;
            y_q        <= y_d;
            mode_q     <= mode_d;
            color_q    <= color_d;
            bar_q      <= bar_d;
            bar_cnt_q  <= bar_cnt_d;
        end
    end

    assign seq_busy         = seq_busy_q;
    assign done             = done_q;
    assign lcd_reset_cursor = rcur_q;
    assign lcd_pix_clk      = pclk_q;
    assign lcd_pix_data     = data_q;
    assign pix_x            = x_q;
    assign pix_y            = y_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb/tb_lcd_frame_sequencer.sv - self-checking bench for lcd_frame_sequencer
module tb_lcd_frame_sequencer;

    localparam int W  = 48;
    localparam int H  = 12;
    localparam int BW = 5;

    logic        clk = 1'b0;
    logic        reset, start, abort, lcd_busy;
    logic [1:0]  mode;
    logic [15:0] color;
    logic        seq_busy, done, lcd_reset_cursor, lcd_pix_clk;
    logic [15:0] lcd_pix_data;
    logic [8:0]  pix_x, pix_y;

    always #31 clk = ~clk;

    lcd_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .BAR_W(BW)) dut (
        .clk_16MHz       (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .mode            (mode),
        .color           (color),
        .seq_busy        (seq_busy),
        .done            (done),
        .lcd_busy        (lcd_busy),
        .lcd_reset_cursor(lcd_reset_cursor),
        .lcd_pix_clk     (lcd_pix_clk),
        .lcd_pix_data    (lcd_pix_data),
        .pix_x           (pix_x),
        .pix_y           (pix_y)
    );

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pix_cnt = 0;
    int   cur_cnt = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   busy_age = 0;
    bit   accept_stall = 1'b0;
    bit   busy_hold = 1'b0;
    bit   cur_seen = 1'b0;

    function automatic logic [15:0] exp_pix(input int m, input logic [15:0] c,
                                            input int x, input int y);
        logic [8:0] xv, yv;
        int idx;
        xv = x[8:0];
        yv = y[8:0];
        case (m)
            0: return c;
            1: return (xv[3] ^ yv[3]) ? ~c : c;
            2: begin
                idx = x / BW;
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            default: return {xv[7:3], yv[8:3], ~xv[7:3]};
        endcase
    endfunction

    // Behavioural driver: accepts a request at a negedge, stays busy 0..2 more cycles.
    initial begin
        pix_t e;
        lcd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_busy) begin
                busy_age++;
                if (busy_age == 1) begin
                    checks++;
                    if ((lcd_pix_clk | lcd_reset_cursor) !== 1'b0) begin
                        failures++;
                        $display("FAIL req_drop got pix=%b cur=%b exp=0", lcd_pix_clk, lcd_reset_cursor);
                    end
                end
                if (busy_cnt > 0) busy_cnt--;
                else if (!busy_hold) lcd_busy = 1'b0;
            end else if (!accept_stall) begin
                if (lcd_pix_clk) begin
                    checks++;
                    if (lcd_reset_cursor !== 1'b0 || !cur_seen) begin
                        failures++;
                        $display("FAIL req_order got cur=%b cur_seen=%b exp cur=0 cur_seen=1", lcd_reset_cursor, cur_seen);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL pix_extra got x=%0d y=%0d d=%h exp=none", pix_x, pix_y, lcd_pix_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pix_x, pix_y, lcd_pix_data} !== {e.x, e.y, e.d}) begin
                            failures++;
                            $display("FAIL pixel got x=%0d y=%0d d=%h exp x=%0d y=%0d d=%h",
                                     pix_x, pix_y, lcd_pix_data, e.x, e.y, e.d);
                        end
                    end
                    pix_cnt++;
                    lcd_busy = 1'b1;
                    busy_age = 0;
                    busy_cnt = $urandom_range(0, 2);
                end else if (lcd_reset_cursor) begin
                    cur_cnt++;
                    cur_seen = 1'b1;
                    lcd_busy = 1'b1;
                    busy_age = 0;
                    busy_cnt = $urandom_range(0, 2);
                end
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pix(input int n);
        int t = 0;
        while (pix_cnt < n && t < 5000) begin
            tick(1);
            t++;
        end
        checks++;
        if (pix_cnt < n) begin
            failures++;
            $display("FAIL wait_pix got=%0d exp>=%0d", pix_cnt, n);
        end
    endtask

    task automatic start_frame(input int m, input logic [15:0] c);
        int t = 0;
        while ((lcd_busy || seq_busy) && t < 1000) begin
            tick(1);
            t++;
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back('{x[8:0], y[8:0], exp_pix(m, c, x, y)});
        pix_cnt  = 0;
        cur_cnt  = 0;
        cur_seen = 1'b0;
        mode  = m[1:0];
        color = c;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        // Scramble the pattern inputs: the frame must use the latched values.
        mode  = ~m[1:0];
        color = ~c;
        checks++;
        if ({seq_busy, lcd_reset_cursor, lcd_pix_clk} !== 3'b110) begin
            failures++;
            $display("FAIL start_latency got busy/cur/pix=%b%b%b exp=110", seq_busy, lcd_reset_cursor, lcd_pix_clk);
        end
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 20000) begin
            tick(1);
            t++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout got done_cnt=%0d exp=%0d", name, done_cnt, d0 + 1);
        end
        checks++;
        if (seq_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_at_done got=%b exp=0", name, seq_busy);
        end
        tick(3);
        checks++;
        if (exp_q.size() != 0 || pix_cnt != W * H || cur_cnt != 1 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL %s_counts got left=%0d pix=%0d cur=%0d done=%0d exp 0/%0d/1/%0d",
                     name, exp_q.size(), pix_cnt, cur_cnt, done_cnt - d0, W * H, 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        checks++;
        if ({seq_busy, done, lcd_reset_cursor, lcd_pix_clk, lcd_pix_data, pix_x, pix_y} !== 38'd0) begin
            failures++;
            $display("FAIL reset_values got busy=%b done=%b cur=%b pix=%b d=%h x=%0d y=%0d exp all 0",
                     seq_busy, done, lcd_reset_cursor, lcd_pix_clk, lcd_pix_data, pix_x, pix_y);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_patterns();
        start_frame(0, 16'hF800); wait_done("solid");
        start_frame(1, 16'h001F); wait_done("checker");
        start_frame(2, 16'h1234); wait_done("bars");
        start_frame(3, 16'h0000); wait_done("gradient");
    endtask

    task automatic test_stall();
        logic [33:0] cap;
        bit bad;
        int t;
        start_frame(0, 16'h07E0);
        wait_pix(5);
        accept_stall = 1'b1;
        t = 0;
        while (!(lcd_pix_clk && !lcd_busy) && t < 100) begin
            tick(1);
            t++;
        end
        cap = {lcd_pix_data, pix_x, pix_y};
        bad = (t >= 100);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (lcd_pix_clk !== 1'b1 || {lcd_pix_data, pix_x, pix_y} !== cap) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_low got pix=%b data=%h exp pix=1 data=%h", lcd_pix_clk, lcd_pix_data, cap[33:18]);
        end
        accept_stall = 1'b0;
        wait_pix(20);
        busy_hold = 1'b1;
        t = 0;
        while (!lcd_busy && t < 100) begin
            tick(1);
            t++;
        end
        tick(3);
        bad = (t >= 100);
        for (int i = 0; i < 30; i++) begin
            if (lcd_pix_clk !== 1'b0 || lcd_reset_cursor !== 1'b0) bad = 1'b1;
            tick(1);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_high got pix=%b cur=%b exp 0/0", lcd_pix_clk, lcd_reset_cursor);
        end
        busy_hold = 1'b0;
        wait_done("stall");
    endtask

    task automatic test_start_ignore();
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({seq_busy, lcd_reset_cursor} !== 2'b00) begin
            failures++;
            $display("FAIL start_with_abort got busy/cur=%b%b exp=00", seq_busy, lcd_reset_cursor);
        end
        start_frame(1, 16'hF81F);
        wait_pix(10);
        mode  = 2'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("start_ignore");
    endtask

    task automatic test_abort();
        int d0;
        start_frame(1, 16'h001F);
        wait_pix(100);
        d0 = done_cnt;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        checks++;
        if ({seq_busy, lcd_reset_cursor, lcd_pix_clk} !== 3'b000) begin
            failures++;
            $display("FAIL abort_drop got busy/cur/pix=%b%b%b exp=000", seq_busy, lcd_reset_cursor, lcd_pix_clk);
        end
        exp_q.delete();
        tick(20);
        checks++;
        if (done_cnt != d0 || seq_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got done=%0d busy=%b exp done=%0d busy=0", done_cnt, seq_busy, d0);
        end
        start_frame(2, 16'h0000);
        wait_done("after_abort");
    endtask

    task automatic test_reset_midframe();
        int d0;
        start_frame(3, 16'h0000);
        wait_pix(100);
        d0 = done_cnt;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({seq_busy, done, lcd_reset_cursor, lcd_pix_clk, lcd_pix_data, pix_x, pix_y} !== 38'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b cur=%b pix=%b d=%h x=%0d y=%0d exp all 0",
                     seq_busy, done, lcd_reset_cursor, lcd_pix_clk, lcd_pix_data, pix_x, pix_y);
        end
        exp_q.delete();
        tick(20);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL reset_no_done got=%0d exp=%0d", done_cnt, d0);
        end
        start_frame(0, 16'h001F);
        wait_done("after_reset");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        color = 16'h0000;
        test_reset();
        test_patterns();
        test_stall();
        test_start_ignore();
        test_abort();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
